// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit teaching CPU: default widths, opcodes
// and the sequencer state encoding.
package cpu_pkg;

    localparam int DW_DEF  = 8;
    localparam int AW_DEF  = 4;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Instructions that need the synchronous RAM read and so a third cycle.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational add/subtract for the accumulator path. Carry on subtract is
// the "no borrow" sense: set when a_i >= b_i.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          sub_i,
    output logic [DW-1:0] result_o,
    output logic          carry_o,
    output logic          zero_o
);

    logic [DW:0] sum;

    // One (DW+1)-bit add or subtract; the top bit is carry-out or borrow.
    always_comb begin
        if (sub_i) begin
            sum     = {1'b0, a_i} - {1'b0, b_i};
            carry_o = ~sum[DW];
        end else begin
            sum     = {1'b0, a_i} + {1'b0, b_i};
            carry_o = sum[DW];
        end
        result_o = sum[DW-1:0];
        zero_o   = (sum[DW-1:0] == '0);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 4-bit teaching CPU.
//
//   state | meaning
//   FETCH | latch rom_data (instruction at pc) into ir
//   EXEC  | execute; last cycle of 2-cycle ops, RAM address out for LDA/ADD/SUB
//   MEM   | consume ram_rdata for LDA/ADD/SUB; last cycle of those ops
//   HALT  | stopped after HLT until rst
//
// The PC lives outside; this block only steers it with pc_en/jmp/jmploc,
// once per instruction in its last cycle. pc_en is forced high during rst
// because the PC only applies its reset on enabled edges.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic [DW-1:0] rom_data,
    output logic          pc_en,
    output logic          jmp,
    output logic [AW-1:0] jmploc,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] acc,
    output logic          flag_c,
    output logic          flag_z,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted
);

    state_e          state_q;
    logic [DW-1:0]   ir_q;
    logic [DW-1:0]   acc_q;
    logic            flag_c_q;
    logic            flag_z_q;
    logic [DW-1:0]   out_data_q;
    logic            out_valid_q;
    logic            halted_q;

    logic [OPC_W-1:0] opcode;
    logic [AW-1:0]    operand;
    logic             jump_taken;

    logic [DW-1:0]   alu_result;
    logic            alu_carry;
    logic            alu_zero;

    // The ROM is addressed by pc outside this block, so pc itself is not needed here.
    logic            unused_pc;
    assign unused_pc = ^pc;

    assign opcode  = ir_q[DW-1 -: OPC_W];
    assign operand = ir_q[AW-1:0];

    assign jump_taken = (opcode == OP_JMP)
                      || ((opcode == OP_JC) && flag_c_q)
                      || ((opcode == OP_JZ) && flag_z_q);

    cpu_alu #(.DW(DW)) u_alu (
        .a_i      (acc_q),
        .b_i      (ram_rdata),
        .sub_i    (opcode == OP_SUB),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    // PC steering and RAM port, decoded from state and ir; rst kills writes and jumps.
    always_comb begin
        pc_en     = 1'b0;
        jmp       = 1'b0;
        jmploc    = operand;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = acc_q;
        if (rst) begin
            pc_en = 1'b1;
        end else begin
            case (state_q)
                EXEC: begin
                    ram_addr = operand;
                    ram_we   = (opcode == OP_STA);
                    if (is_mem_op(opcode) || (opcode == OP_HLT)) begin
                        pc_en = 1'b0;
                    end else if (jump_taken) begin
                        jmp = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                MEM: begin
                    ram_addr = operand;
                    pc_en    = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and all architectural registers.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            acc_q       <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    ir_q    <= rom_data;
                    state_q <= EXEC;
                end
                EXEC: begin
                    state_q <= FETCH;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            state_q <= MEM;
                        end
                        OP_LDI: begin
                            acc_q <= {{(DW-AW){1'b0}}, operand};
                        end
                        OP_OUT: begin
                            out_data_q  <= acc_q;
                            out_valid_q <= 1'b1;
                        end
                        OP_HLT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state_q <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    state_q <= FETCH;
                    if (opcode == OP_LDA) begin
                        acc_q <= ram_rdata;
                    end else begin
                        acc_q    <= alu_result;
                        flag_c_q <= alu_carry;
                        flag_z_q <= alu_zero;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: external PC, async ROM and sync-read RAM around the
// DUT, an instruction-level model of the CPU checked every cycle, and directed
// programs with hand-computed results.
module tb_cpu_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc = '0;
    logic [DW-1:0] rom_data;
    logic          pc_en;
    logic          jmp;
    logic [AW-1:0] jmploc;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] acc;
    logic          flag_c;
    logic          flag_z;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;

    logic [DW-1:0] rom [16];
    logic [DW-1:0] ram [16];

    int n_cmp = 0;
    int n_err = 0;

    cpu_sequencer #(.DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .pc        (pc),
        .rom_data  (rom_data),
        .pc_en     (pc_en),
        .jmp       (jmp),
        .jmploc    (jmploc),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    assign rom_data = rom[pc];

    // Program counter: reset only when enabled, load has priority.
    always @(posedge CLK) begin
        if (jmp)
            pc <= jmploc;
        else if (pc_en)
            pc <= rst ? 4'h0 : pc + 4'h1;
    end

    // Synchronous-read data RAM.
    always @(posedge CLK) begin
        if (ram_we)
            ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    int          m_pc;
    logic [7:0]  m_acc, m_out;
    logic        m_c, m_z, m_halt, m_ovp;
    logic [7:0]  m_ram [16];
    logic [3:0]  m_opc, m_opr;
    int          m_len, ph;
    bit          m_taken;
    logic [8:0]  m_sum;

    int cyc, halt_cyc, cnt_pe, cnt_j, cnt_we, cnt_ov, last_ov, ov_int;
    logic [3:0] last_jl;

    always @(negedge CLK) begin
        if (rst) begin
            chk("rst_pc_en", pc_en, 1);
            chk("rst_jmp", jmp, 0);
            chk("rst_ram_we", ram_we, 0);
            m_pc = 0; m_acc = 0; m_out = 0; m_c = 0; m_z = 0;
            m_halt = 0; m_ovp = 0; ph = 0; m_len = 2;
            cyc = 0; halt_cyc = -1;
        end else begin
            if (pc_en) cnt_pe++;
            if (jmp) begin cnt_j++; last_jl = jmploc; end
            if (ram_we) cnt_we++;
            if (out_valid) begin
                if (cnt_ov > 0) ov_int = cyc - last_ov;
                last_ov = cyc;
                cnt_ov++;
            end
            if (halted && halt_cyc < 0) halt_cyc = cyc;
            cyc++;

            chk("acc", acc, m_acc);
            chk("flag_c", flag_c, m_c);
            chk("flag_z", flag_z, m_z);
            chk("out_data", out_data, m_out);

            if (m_halt) begin
                chk("halted", halted, 1);
                chk("halt_pc", pc, m_pc);
                chk("halt_pc_en", pc_en, 0);
                chk("halt_jmp", jmp, 0);
                chk("halt_we", ram_we, 0);
                chk("halt_out_valid", out_valid, 0);
            end else begin
                chk("halted", halted, 0);
                if (ph == 0) begin
                    m_opc   = rom[m_pc][7:4];
                    m_opr   = rom[m_pc][3:0];
                    m_len   = (m_opc inside {4'h1, 4'h2, 4'h3}) ? 3 : 2;
                    m_taken = (m_opc == 4'h6) || (m_opc == 4'h7 && m_c) || (m_opc == 4'h8 && m_z);
                    chk("fetch_pc", pc, m_pc);
                    chk("out_valid", out_valid, m_ovp);
                    m_ovp = 0;
                end else begin
                    chk("out_valid", out_valid, 0);
                end
                chk("pc_en", pc_en, (ph == m_len - 1) && !m_taken && (m_opc != 4'hF));
                chk("jmp", jmp, (ph == m_len - 1) && m_taken);
                if (jmp) chk("jmploc", jmploc, m_opr);
                chk("ram_we", ram_we, (ph == 1) && (m_opc == 4'h4));
                if (ram_we) chk("ram_wdata", ram_wdata, m_acc);
                chk("ram_addr", ram_addr, (ph >= 1) ? m_opr : 4'h0);

                if (ph == m_len - 1) begin
                    case (m_opc)
                        4'h1: m_acc = m_ram[m_opr];
                        4'h2: begin
                            m_sum = {1'b0, m_acc} + {1'b0, m_ram[m_opr]};
                            m_acc = m_sum[7:0]; m_c = m_sum[8]; m_z = (m_acc == 0);
                        end
                        4'h3: begin
                            m_c = (m_acc >= m_ram[m_opr]);
                            m_acc = m_acc - m_ram[m_opr]; m_z = (m_acc == 0);
                        end
                        4'h4: m_ram[m_opr] = m_acc;
                        4'h5: m_acc = {4'h0, m_opr};
                        4'hE: begin m_out = m_acc; m_ovp = 1; end
                        4'hF: m_halt = 1;
                        default: ;
                    endcase
                    if (m_taken) m_pc = m_opr;
                    else if (m_opc != 4'hF) m_pc = (m_pc + 1) % 16;
                    ph = 0;
                end else begin
                    ph++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic begin_test();
        @(posedge CLK); #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rom[i] = 8'hF0;
            ram[i] = 8'h00;
        end
    endtask

    task automatic go();
        for (int i = 0; i < 16; i++) m_ram[i] = ram[i];
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        rst = 1'b0;
        cnt_pe = 0; cnt_j = 0; cnt_we = 0; cnt_ov = 0; last_ov = 0; ov_int = 0; last_jl = 4'hX;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) @(posedge CLK);
        #1;
        chk("halt_reached", halted, 1);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        // 1: LDI 5, OUT, HLT
        begin_test();
        rom[0] = 8'h55; rom[1] = 8'hE0; rom[2] = 8'hF0;
        go();
        chk("t1_reset_acc", acc, 0);
        chk("t1_reset_out_valid", out_valid, 0);
        wait_halt(50);
        chk("t1_out_data", out_data, 8'h05);
        chk("t1_out_pulses", cnt_ov, 1);
        chk("t1_pc_frozen", pc, 2);
        chk("t1_pc_en_pulses", cnt_pe, 2);
        chk("t1_halt_cycle", halt_cyc, 6);

        // 2: LDA 3, ADD 4, OUT, HLT with 0xF0 + 0x20
        begin_test();
        ram[3] = 8'hF0; ram[4] = 8'h20;
        rom[0] = 8'h13; rom[1] = 8'h24; rom[2] = 8'hE0; rom[3] = 8'hF0;
        go();
        wait_halt(50);
        chk("t2_out_data", out_data, 8'h10);
        chk("t2_c", flag_c, 1);
        chk("t2_z", flag_z, 0);
        chk("t2_halt_cycle", halt_cyc, 10);

        // 3: SUB to zero, JZ taken over OUT/HLT
        begin_test();
        ram[1] = 8'h07;
        rom[0] = 8'h57; rom[1] = 8'h31; rom[2] = 8'h85; rom[3] = 8'hE0;
        rom[4] = 8'hF0; rom[5] = 8'h59; rom[6] = 8'hE0; rom[7] = 8'hF0;
        go();
        wait_halt(60);
        chk("t3_z", flag_z, 1);
        chk("t3_c", flag_c, 1);
        chk("t3_jmp_pulses", cnt_j, 1);
        chk("t3_jmploc", last_jl, 5);
        chk("t3_out_data", out_data, 8'h09);
        chk("t3_pc", pc, 7);

        // 4: JC not taken with C=0
        begin_test();
        rom[0] = 8'h78; rom[1] = 8'h53; rom[2] = 8'hE0; rom[3] = 8'hF0;
        go();
        wait_halt(50);
        chk("t4_jmp_pulses", cnt_j, 0);
        chk("t4_out_data", out_data, 8'h03);
        chk("t4_pc", pc, 3);
        chk("t4_halt_cycle", halt_cyc, 8);

        // 5: store/load loop
        begin_test();
        rom[0] = 8'h52; rom[1] = 8'h46; rom[2] = 8'h16; rom[3] = 8'hE0; rom[4] = 8'h60;
        go();
        for (int i = 0; i < 100 && cnt_ov < 3; i++) @(posedge CLK);
        #1;
        chk("t5_out_pulses", cnt_ov, 3);
        chk("t5_out_interval", ov_int, 11);
        chk("t5_we_pulses", cnt_we, 3);
        chk("t5_ram6", ram[6], 8'h02);
        chk("t5_out_data", out_data, 8'h02);
        chk("t5_jmploc", last_jl, 0);

        // 6: reset during MEM of ADD
        begin_test();
        ram[5] = 8'h04;
        rom[0] = 8'h53; rom[1] = 8'h25; rom[2] = 8'hE0; rom[3] = 8'hF0;
        go();
        repeat (4) @(posedge CLK);
        #1;
        chk("t6_acc_before", acc, 3);
        chk("t6_in_mem_addr", ram_addr, 5);
        rst = 1'b1;
        @(posedge CLK); #1;
        chk("t6_acc_reset", acc, 0);
        chk("t6_c_reset", flag_c, 0);
        chk("t6_z_reset", flag_z, 0);
        chk("t6_pc_reset", pc, 0);
        @(posedge CLK); #1;
        rst = 1'b0;
        cnt_pe = 0; cnt_j = 0; cnt_we = 0; cnt_ov = 0;
        chk("t6_first_fetch_pc", pc, 0);
        wait_halt(50);
        chk("t6_out_data", out_data, 8'h07);
        chk("t6_halt_cycle", halt_cyc, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
